// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin over WIDTH bits, one full-adder step per clock, LSB first.
// The result is captured into sum/cout on the last bit, and done pulses for one cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             c_reg, c_next;
    logic             cout_reg, cout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             s_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] acc_shift;

    assign s_bit     = sa_reg[0] ^ sb_reg[0] ^ c_reg;
    assign carry_bit = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);

    // Accumulator shifts right with the new sum bit entering at the MSB;
    // after WIDTH steps the first computed bit has reached bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_acc
            assign acc_shift[gi] = acc_reg[gi+1];
        end
    endgenerate
    assign acc_shift[WIDTH-1] = s_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            c_reg     <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            acc_reg   <= acc_next;
            sum_reg   <= sum_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
            cout_reg  <= cout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        acc_next   = acc_reg;
        sum_next   = sum_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        cout_next  = cout_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next    = a;
                    sb_next    = b;
                    c_next     = cin;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                sa_next  = sa_reg >> 1;
                sb_next  = sb_reg >> 1;
                c_next   = carry_bit;
                acc_next = acc_shift;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    sum_next   = acc_shift;
                    cout_next  = carry_bit;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Status flags are registered from the next state so outputs come straight from flops.
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, expected results
// queued at stimulus time and compared whenever done pulses.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n8, start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       rst_n1, start1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] last8;
    logic [8:0] e8;
    logic [1:0] e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Result monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("dut8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("dut8_sum", 32'(sum8), 32'(e8[7:0]));
                check("dut8_cout", 32'(cout8), 32'(e8[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut1_sum", 32'(sum1), 32'(e1[0]));
                check("dut1_cout", 32'(cout1), 32'(e1[1]));
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] exp;
        int lat;
        int busy_cnt;
        bit held;
        exp = 9'(a) + 9'(b) + 9'(ci);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~ci;
        lat = -1; busy_cnt = 0; held = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin
                lat = k;
                break;
            end
            if (busy8) busy_cnt++;
            if ({cout8, sum8} !== last8) held = 1'b0;
            @(negedge clk);
        end
        $display("op8 %02h+%02h+%0d -> expect %03h, latency %0d", a, b, ci, exp, lat);
        check("latency", 32'(lat), 32'd8);
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        check("hold_during_run", 32'(held), 32'd1);
        check("busy_in_done", 32'(busy8), 32'd0);
        last8 = exp;
        @(negedge clk);
        check("done_one_cycle", 32'(done8), 32'd0);
    endtask

    initial begin
        int t1, t2;
        logic prevb;
        rst_n8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst_n1 = 1'b0; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        last8 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_sum", 32'(sum8), 32'd0);
        check("reset_cout", 32'(cout8), 32'd0);
        rst_n8 = 1'b1; rst_n1 = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h00, 8'h00, 1'b0);

        // Continuous start with operands changed during the first RUN.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        q8.push_back(9'h0FF);
        t1 = -1; t2 = -1; prevb = busy8;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy8 && !prevb) begin
                if (t1 < 0) begin
                    t1 = cyc; a8 = 8'hAA; b8 = 8'h55;
                end else begin
                    t2 = cyc; start8 = 1'b0;
                    break;
                end
            end
            prevb = busy8;
        end
        start8 = 1'b0;
        check("reaccept_gap", 32'(t2 - t1), 32'd10);
        repeat (12) @(negedge clk);
        check("queue8_drained", 32'(q8.size()), 32'd0);
        last8 = 9'h0FF;

        // Reset in the middle of an operation, previous result 0x30.
        op8(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", 32'(busy8), 32'd1);
        rst_n8 = 1'b0;
        #1;
        check("midrun_reset_sum", 32'(sum8), 32'd0);
        check("midrun_reset_cout", 32'(cout8), 32'd0);
        check("midrun_reset_busy", 32'(busy8), 32'd0);
        check("midrun_reset_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        last8 = '0;
        repeat (15) @(negedge clk);
        check("idle_after_reset", 32'(busy8), 32'd0);
        op8(8'h01, 8'h01, 1'b0);

        // WIDTH=1: full-adder truth table, done one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            $display("op1 a=%0d b=%0d cin=%0d", v[2], v[1], v[0]);
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy_after_accept", 32'(busy1), 32'd1);
            @(negedge clk);
            check("w1_done_latency", 32'(done1), 32'd1);
            @(negedge clk);
        end
        @(negedge clk);
        check("queue1_drained", 32'(q1.size()), 32'd0);
        check("queue8_final", 32'(q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
